fifo_rr_arbiter: RTL and testbench
==================================

// Module: fifo_rr_arbiter
// PURPOSE
//  Shares one synchronous FIFO between N write requesters using round-robin arbitration with packet lock.
//  Pointer and level control comes from a fifo_sync instance; storage is a register array inside this block.
//  Each entry carries data plus source index. The read side is a simple valid/ack consumer port.
//  Sits between peripheral producers (APU/PPU/DMA event sources) and a single consumer.
// PARAMETERS
//  N        4  number of requesters (>=2)
//  W        8  data width per entry
//  DEPTH_N  3  log2 FIFO depth (depth = 2**DEPTH_N)
// PORTS
//  clk       in   1                clock, all state on rising edge
//  n_reset   in   1                asynchronous reset, active low
//  flush     in   1                sync clear: FIFO, lock, RR pointer, error flags
//  req       in   N                per-requester write request
//  last      in   N                beat is final of packet (1 = single-beat)
//  wdata     in   N*W              per-requester data, slice i = wdata[i*W +: W]
//  ack       out  N                one-hot, combinational: beat of requester i written this cycle
//  rd_valid  out  1                FIFO non-empty (= ~empty)
//  rd_data   out  W                data at tail
//  rd_src    out  $clog2(N)        requester index at tail
//  rd_ack    in   1                consumer pops tail this cycle
//  full      out  1                FIFO full
//  err_ovf   out  1                sticky: write attempted while full (never set by arbiter; guards misuse)
//  err_udf   out  1                sticky: rd_ack while empty
// BEHAVIOUR
//  Reset/flush: ack=0, rd_valid=0, full=0, err_*=0, state IDLE, rr_ptr=0, lock_id=0; storage not cleared.
//  States: IDLE, LOCKED.
//   IDLE: candidates = req & {N{~full}}. Pick first set bit scanning rr_ptr, rr_ptr+1 .. mod N.
//    Winner i: ack[i]=1, entry {i, wdata[i]} written at head.
//    If last[i]=1: stay IDLE, rr_ptr <= (i+1) mod N.
//    If last[i]=0: -> LOCKED, lock_id <= i.
//   LOCKED: only lock_id eligible; ack[lock_id] = req[lock_id] & ~full.
//    Other requesters are stalled even if FIFO has room.
//    On an acked beat with last=1: -> IDLE, rr_ptr <= (lock_id+1) mod N.
//    A dropped req mid-packet holds LOCKED (no timeout).
//  At most one ack bit per cycle. ack never asserts while full.
//  A write when full in the same cycle as rd_ack is NOT accepted; no pass-through (matches fifo_sync: head advances only on ~full).
//  Write latency: entry visible on rd_valid the cycle after ack (level registered).
//  Read: rd_data/rd_src combinational from storage[tail]. rd_ack & rd_valid advances tail next edge.
//  Simultaneous write+read when neither full nor empty: level unchanged, both pointers advance.
//  Pointers wrap mod 2**DEPTH_N via DEPTH_N-bit head/tail.
//  err_udf <= err_udf | fifo_sync.underrun. err_ovf <= err_ovf | fifo_sync.overrun. Both cleared only by flush/reset.
//  wrreq to fifo_sync = |ack. rdack = rd_ack. flush passes through.
//  flush has priority over any same-cycle req/rd_ack. That cycle's acks are still driven combinationally, but the data is discarded.
//  Reset asserted mid-packet: returns to IDLE; the partial packet already in the FIFO is lost with the FIFO state.
// STRUCTURE
//  Package fifo_arb_pkg: typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t.
//  Package also holds the rr_pick function (rotate-priority one-hot select, parameterised width).
//  Sub-module: fifo_sync #(DEPTH_N) u_ptr for head/tail/empty/full/underrun/overrun.
//  Local: storage array [2**DEPTH_N] of {src,data}, written at head when |ack.
// TESTING
//  1 Reset, N=4, req=4'b1111, last=4'b1111, no rd_ack -> ack sequence 0001,0010,0100,1000,0001...;
//    full after 8 acks; ack=0 thereafter.
//  2 Fill 8 entries, then req=4'b0001 plus rd_ack the same cycle -> no ack that cycle; next cycle ack=0001; err_ovf stays 0.
//  3 Req1 sends 3 beats last=0,0,1 while req0/req2 held -> acks 0010x3 consecutive, then 0100 (rr_ptr=2).
//  4 rd_ack when empty -> err_udf=1 next cycle, stays 1; flush -> err_udf=0, rd_valid=0.
//  5 Steady write+read at depth 4 -> level constant; rd_src/rd_data order equals ack order across head/tail wrap at 7->0.
//  6 n_reset pulse while LOCKED mid-packet -> state IDLE, rd_valid=0, next grant from requester 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and the rotate-priority picker for the round-robin FIFO arbiter.
// rr_pick works on a zero-padded 32-bit candidate vector, so any requester count up to 32 can use it.
package fifo_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   localparam int RR_MAX_N = 32;

   // Returns the index of the first set candidate scanning ptr, ptr+1 .. mod n, or -1 if none.
   function automatic int rr_pick(input logic [RR_MAX_N-1:0] cand, input int ptr, input int n);
      int idx;
      int win;
      win = -1;
      for (int k = 0; k < RR_MAX_N; k++) begin
         idx = (ptr + k >= n) ? (ptr + k - n) : (ptr + k);
         if ((k < n) && (win < 0) && cand[idx[4:0]]) begin
            win = idx;
         end else begin
            win = win;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/fifo_sync.sv
// Pointer and level control for a 2**DEPTH_N entry synchronous FIFO; storage lives in the parent.
// empty/full are registered from the next level, so a write shows up on ~empty one cycle later.
module fifo_sync #(
   parameter int DEPTH_N = 3
) (
   input  logic               clk,
   input  logic               n_reset,
   input  logic               flush,
   input  logic               wrreq,
   input  logic               rdack,
   output logic [DEPTH_N-1:0] head,
   output logic [DEPTH_N-1:0] tail,
   output logic               empty,
   output logic               full,
   output logic               underrun,
   output logic               overrun
);

   localparam int CW = DEPTH_N + 1;
   localparam logic [CW-1:0] DEPTH = CW'(2 ** DEPTH_N);

   logic [CW-1:0]      count_q, count_d;
   logic [DEPTH_N-1:0] head_q, head_d, tail_q, tail_d;
   logic               empty_q, full_q;
   logic               do_wr_s, do_rd_s;

   // A write while full is refused even when the same cycle pops, so there is no pass-through.
   always_comb begin
      do_wr_s = wrreq & ~full_q;
      do_rd_s = rdack & ~empty_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_wr_s) begin
            head_d = head_q + DEPTH_N'(1);
         end else begin
            head_d = head_q;
         end
         if (do_rd_s) begin
            tail_d = tail_q + DEPTH_N'(1);
         end else begin
            tail_d = tail_q;
         end
         count_d = count_q + CW'(do_wr_s) - CW'(do_rd_s);
      end
   end

   // Pointer, level and flag registers.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         empty_q <= (count_d == '0);
         full_q  <= (count_d == DEPTH);
      end
   end

   assign head     = head_q;
   assign tail     = tail_q;
   assign empty    = empty_q;
   assign full     = full_q;
   assign underrun = rdack & empty_q;
   assign overrun  = wrreq & full_q;

endmodule

// File: rtl/fifo_rr_arbiter.sv
// N write requesters share one FIFO via round-robin arbitration; a multi-beat packet locks the grant
// to its requester until its last beat. Each entry stores {source index, data}.
module fifo_rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N       = 4,
   parameter int W       = 8,
   parameter int DEPTH_N = 3
) (
   input  logic                 clk,
   input  logic                 n_reset,
   input  logic                 flush,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         last,
   input  logic [N*W-1:0]       wdata,
   output logic [N-1:0]         ack,
   output logic                 rd_valid,
   output logic [W-1:0]         rd_data,
   output logic [$clog2(N)-1:0] rd_src,
   input  logic                 rd_ack,
   output logic                 full,
   output logic                 err_ovf,
   output logic                 err_udf
);

   localparam int SW    = $clog2(N);
   localparam int DEPTH = 2 ** DEPTH_N;

   arb_state_t          state_q;
   logic [SW-1:0]       rr_ptr_q, lock_id_q;
   logic                err_ovf_q, err_udf_q;
   logic [W-1:0]        mem_data_q [DEPTH];
   logic [SW-1:0]       mem_src_q  [DEPTH];

   logic [RR_MAX_N-1:0] cand_ext_s;
   int                  win_s;
   logic [N-1:0]        ack_s;
   logic                win_valid_s, win_last_s, wr_en_s;
   logic [SW-1:0]       win_idx_s, next_ptr_s;
   logic [W-1:0]        wdata_sel_s;
   logic [DEPTH_N-1:0]  head_s, tail_s;
   logic                empty_s, full_s, underrun_s, overrun_s;

   fifo_sync #(.DEPTH_N(DEPTH_N)) u_ptr (
      .clk      (clk),
      .n_reset  (n_reset),
      .flush    (flush),
      .wrreq    (|ack_s),
      .rdack    (rd_ack),
      .head     (head_s),
      .tail     (tail_s),
      .empty    (empty_s),
      .full     (full_s),
      .underrun (underrun_s),
      .overrun  (overrun_s)
   );

   // Grant selection: rotating priority when idle, only the lock holder while a packet is open.
   always_comb begin
      cand_ext_s = '0;
      win_s      = -1;
      if (state_q == ARB_IDLE) begin
         cand_ext_s[N-1:0] = req & {N{~full_s}};
         win_s             = rr_pick(cand_ext_s, int'(rr_ptr_q), N);
      end else begin
         if (req[lock_id_q] && !full_s) begin
            win_s = int'(lock_id_q);
         end else begin
            win_s = -1;
         end
      end
      ack_s       = '0;
      wdata_sel_s = '0;
      for (int i = 0; i < N; i++) begin
         ack_s[i] = (win_s == i);
         if (win_s == i) begin
            wdata_sel_s = wdata[i*W +: W];
         end else begin
            wdata_sel_s = wdata_sel_s;
         end
      end
      win_valid_s = |ack_s;
      win_last_s  = |(ack_s & last);
      win_idx_s   = SW'(win_s);
      next_ptr_s  = (win_s >= N - 1) ? '0 : SW'(win_s + 1);
      wr_en_s     = win_valid_s & ~flush;
   end

   // Arbiter FSM and sticky error flags; flush outranks any same-cycle grant.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q   <= ARB_IDLE;
         rr_ptr_q  <= '0;
         lock_id_q <= '0;
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else if (flush) begin
         state_q   <= ARB_IDLE;
         rr_ptr_q  <= '0;
         lock_id_q <= '0;
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         err_ovf_q <= err_ovf_q | overrun_s;
         err_udf_q <= err_udf_q | underrun_s;
         case (state_q)
            ARB_IDLE: begin
               if (win_valid_s && win_last_s) begin
                  rr_ptr_q <= next_ptr_s;
               end else if (win_valid_s) begin
                  state_q   <= ARB_LOCKED;
                  lock_id_q <= win_idx_s;
               end else begin
                  state_q <= ARB_IDLE;
               end
            end
            ARB_LOCKED: begin
               if (win_valid_s && win_last_s) begin
                  state_q  <= ARB_IDLE;
                  rr_ptr_q <= next_ptr_s;
               end else begin
                  state_q <= ARB_LOCKED;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   // Entry storage is deliberately not reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_data_q[head_s] <= wdata_sel_s;
         mem_src_q[head_s]  <= win_idx_s;
      end
   end

   assign ack      = ack_s;
   assign rd_valid = ~empty_s;
   assign rd_data  = mem_data_q[tail_s];
   assign rd_src   = mem_src_q[tail_s];
   assign full     = full_s;
   assign err_ovf  = err_ovf_q;
   assign err_udf  = err_udf_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed plus randomized bench for fifo_rr_arbiter against a queue-based reference model.
module tb_fifo_rr_arbiter;

   localparam int N       = 4;
   localparam int W       = 8;
   localparam int DEPTH_N = 3;
   localparam int DEPTH   = 8;
   localparam int SW      = 2;

   logic           clk     = 1'b0;
   logic           n_reset = 1'b1;
   logic           flush   = 1'b0;
   logic           rd_ack  = 1'b0;
   logic [N-1:0]   req     = '0;
   logic [N-1:0]   last    = '0;
   logic [N*W-1:0] wdata   = '0;
   logic [N-1:0]   ack;
   logic           rd_valid, full, err_ovf, err_udf;
   logic [W-1:0]   rd_data;
   logic [SW-1:0]  rd_src;

   int passed = 0;
   int total  = 0;

   logic [SW+W-1:0] m_q [$];
   int              m_rr   = 0;
   int              m_lock = -1;
   logic            m_ovf  = 1'b0;
   logic            m_udf  = 1'b0;

   fifo_rr_arbiter #(.N(N), .W(W), .DEPTH_N(DEPTH_N)) dut (
      .clk      (clk),
      .n_reset  (n_reset),
      .flush    (flush),
      .req      (req),
      .last     (last),
      .wdata    (wdata),
      .ack      (ack),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rd_src   (rd_src),
      .rd_ack   (rd_ack),
      .full     (full),
      .err_ovf  (err_ovf),
      .err_udf  (err_udf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Expected one-hot grant from the model state and the current inputs.
   function automatic logic [N-1:0] exp_ack();
      logic [N-1:0] r;
      r = '0;
      if (m_q.size() == DEPTH) return r;
      if (m_lock >= 0) begin
         if (((req >> m_lock) & N'(1)) != '0) r = N'(1) << m_lock;
         return r;
      end
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_rr + k) % N;
         if (((req >> i) & N'(1)) != '0) begin
            r = N'(1) << i;
            return r;
         end
      end
      return r;
   endfunction

   task automatic check_model();
      logic [N-1:0] ea;
      ea = exp_ack();
      check("ack", 32'(ack), 32'(ea));
      check("rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
      check("full", 32'(full), 32'(m_q.size() == DEPTH));
      check("err_ovf", 32'(err_ovf), 32'(m_ovf));
      check("err_udf", 32'(err_udf), 32'(m_udf));
      if (m_q.size() != 0) begin
         check("rd_data", 32'(rd_data), 32'(W'(m_q[0])));
         check("rd_src", 32'(rd_src), 32'(SW'(m_q[0] >> W)));
      end
   endtask

   // Apply one cycle of inputs (called just after a rising edge) and compare against the model.
   task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic ra, input logic fl);
      req    = r;
      last   = l;
      rd_ack = ra;
      flush  = fl;
      for (int i = 0; i < N; i++) wdata[i*W +: W] = W'($urandom);
      #1;
      check_model();
   endtask

   // Update the model with this cycle's outcome, then move to just past the next rising edge.
   task automatic advance();
      logic [N-1:0] ea;
      int w;
      ea = exp_ack();
      w  = -1;
      for (int i = 0; i < N; i++) if (ea == (N'(1) << i)) w = i;
      if (flush) begin
         m_q.delete();
         m_rr   = 0;
         m_lock = -1;
         m_ovf  = 1'b0;
         m_udf  = 1'b0;
      end else begin
         if (rd_ack) begin
            if (m_q.size() == 0) m_udf = 1'b1;
            else void'(m_q.pop_front());
         end
         if (w >= 0) begin
            m_q.push_back({SW'(w), W'(wdata >> (w * W))});
            if (((last >> w) & N'(1)) != '0) begin
               m_lock = -1;
               m_rr   = (w + 1) % N;
            end else begin
               m_lock = w;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req     = '0;
      last    = '0;
      rd_ack  = 1'b0;
      flush   = 1'b0;
      n_reset = 1'b0;
      #2;
      m_q.delete();
      m_rr   = 0;
      m_lock = -1;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_err_udf", 32'(err_udf), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      @(negedge clk);
      n_reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      do_reset();

      // Eight single-beat writes rotate through all requesters, then the FIFO is full.
      for (int k = 0; k < DEPTH; k++) begin
         drive(4'b1111, 4'b1111, 1'b0, 1'b0);
         check("t1_rr_ack", 32'(ack), 32'(4'b0001 << (k % N)));
         advance();
      end
      drive(4'b1111, 4'b1111, 1'b0, 1'b0);
      check("t1_full", 32'(full), 32'd1);
      check("t1_no_ack", 32'(ack), 32'd0);
      advance();

      // Write while full with a same-cycle pop is refused; it goes through on the next cycle.
      drive(4'b0001, 4'b1111, 1'b1, 1'b0);
      check("t2_full_rd_ack", 32'(ack), 32'd0);
      advance();
      drive(4'b0001, 4'b1111, 1'b0, 1'b0);
      check("t2_ack_after", 32'(ack), 32'(4'b0001));
      check("t2_err_ovf", 32'(err_ovf), 32'd0);
      advance();

      // Packet lock: requester 1 sends three beats while 0 and 2 wait.
      drive(4'b0000, 4'b0000, 1'b0, 1'b1);
      advance();
      drive(4'b0001, 4'b1111, 1'b0, 1'b0);
      check("t3_pre", 32'(ack), 32'(4'b0001));
      advance();
      drive(4'b0111, 4'b0000, 1'b0, 1'b0);
      check("t3_beat0", 32'(ack), 32'(4'b0010));
      advance();
      drive(4'b0111, 4'b0000, 1'b0, 1'b0);
      check("t3_beat1", 32'(ack), 32'(4'b0010));
      advance();
      drive(4'b0111, 4'b0010, 1'b0, 1'b0);
      check("t3_beat2", 32'(ack), 32'(4'b0010));
      advance();
      drive(4'b0111, 4'b1111, 1'b0, 1'b0);
      check("t3_next", 32'(ack), 32'(4'b0100));
      advance();

      // Underflow is sticky until flush.
      drive(4'b0000, 4'b0000, 1'b0, 1'b1);
      advance();
      drive(4'b0000, 4'b0000, 1'b1, 1'b0);
      advance();
      drive(4'b0000, 4'b0000, 1'b0, 1'b0);
      check("t4_udf_set", 32'(err_udf), 32'd1);
      advance();
      drive(4'b0000, 4'b0000, 1'b0, 1'b0);
      check("t4_udf_hold", 32'(err_udf), 32'd1);
      advance();
      drive(4'b0000, 4'b0000, 1'b0, 1'b1);
      advance();
      drive(4'b0000, 4'b0000, 1'b0, 1'b0);
      check("t4_udf_clr", 32'(err_udf), 32'd0);
      check("t4_rd_valid", 32'(rd_valid), 32'd0);
      advance();

      // Steady write+read at four entries across the pointer wrap.
      for (int k = 0; k < 4; k++) begin
         drive(4'b1111, 4'b1111, 1'b0, 1'b0);
         advance();
      end
      for (int k = 0; k < 12; k++) begin
         drive(4'b1111, 4'b1111, 1'b1, 1'b0);
         check("t5_valid", 32'(rd_valid), 32'd1);
         check("t5_not_full", 32'(full), 32'd0);
         advance();
      end

      // Reset in the middle of a locked packet.
      drive(4'b0000, 4'b0000, 1'b0, 1'b1);
      advance();
      drive(4'b0100, 4'b0000, 1'b0, 1'b0);
      check("t6_lock", 32'(ack), 32'(4'b0100));
      advance();
      drive(4'b0100, 4'b0000, 1'b0, 1'b0);
      advance();
      do_reset();
      drive(4'b1111, 4'b1111, 1'b0, 1'b0);
      check("t6_after_rst", 32'(ack), 32'(4'b0001));
      advance();

      // Random traffic with occasional flushes.
      for (int k = 0; k < 400; k++) begin
         drive(N'($urandom), N'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));
         advance();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
